// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: stacks the return PC on entry, jumps to the vector,
// and on RETI unstacks the PC, restores SP and acknowledges the interrupt controller.
module int_sequencer #(
   parameter logic [15:0] SP_RESET = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cauch_int,
   input  logic [15:0] int_address,
   input  logic        instr_boundary,
   input  logic        reti,
   input  logic        ei,
   input  logic        di,
   input  logic [15:0] pc_in,
   input  logic [15:0] sp_in,
   output logic [15:0] pc_out,
   output logic        pc_we,
   output logic [15:0] sp_out,
   output logic        sp_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic        mem_ready,
   output logic        clr_int,
   output logic        busy,
   output logic        ie,
   output logic        in_isr
);

   typedef enum logic [3:0] {
      IDLE, PUSH_HI, PUSH_LO, VECTOR, IN_ISR, POP_LO, POP_HI, RESTORE, ACK
   } state_t;

   state_t      state, state_next;
   logic        ie_next;
   logic [15:0] ret_pc, ret_pc_next;
   logic [15:0] sp_work, sp_work_next;
   logic [15:0] vec, vec_next;
   logic        accept;

   // State and working registers; reset abandons any sequence in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ie      <= 1'b0;
         ret_pc  <= 16'h0000;
         sp_work <= SP_RESET;
         vec     <= 16'h0000;
      end else begin
         state   <= state_next;
         ie      <= ie_next;
         ret_pc  <= ret_pc_next;
         sp_work <= sp_work_next;
         vec     <= vec_next;
      end
   end

   assign accept = (state == IDLE) && cauch_int && ie && instr_boundary;

   // Next-state, datapath updates and all bus/strobe outputs
   always_comb begin
      state_next   = state;
      ret_pc_next  = ret_pc;
      sp_work_next = sp_work;
      vec_next     = vec;
      ie_next      = ie;
      pc_out       = 16'h0000;
      pc_we        = 1'b0;
      sp_out       = 16'h0000;
      sp_we        = 1'b0;
      mem_addr     = 16'h0000;
      mem_wdata    = 8'h00;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      clr_int      = 1'b0;
      busy         = 1'b0;
      in_isr       = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_next   = PUSH_HI;
               ret_pc_next  = pc_in;
               sp_work_next = sp_in;
               vec_next     = int_address;
            end
         end
         PUSH_HI: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_work;
            mem_wdata = ret_pc[15:8];
            if (mem_ready) begin
               sp_work_next = sp_work - 16'd1;
               state_next   = PUSH_LO;
            end
         end
         PUSH_LO: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp_work;
            mem_wdata = ret_pc[7:0];
            if (mem_ready) begin
               sp_work_next = sp_work - 16'd1;
               state_next   = VECTOR;
            end
         end
         VECTOR: begin
            busy       = 1'b1;
            pc_out     = vec;
            pc_we      = 1'b1;
            sp_out     = sp_work;
            sp_we      = 1'b1;
            state_next = IN_ISR;
         end
         IN_ISR: begin
            // No nesting: pending interrupts are not sampled while a handler runs
            in_isr = 1'b1;
            if (reti) begin
               sp_work_next = sp_in;
               state_next   = POP_LO;
            end
         end
         POP_LO: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = sp_work + 16'd1;
            if (mem_ready) begin
               ret_pc_next[7:0] = mem_rdata;
               sp_work_next     = sp_work + 16'd1;
               state_next       = POP_HI;
            end
         end
         POP_HI: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = sp_work + 16'd1;
            if (mem_ready) begin
               ret_pc_next[15:8] = mem_rdata;
               sp_work_next      = sp_work + 16'd1;
               state_next        = RESTORE;
            end
         end
         RESTORE: begin
            busy       = 1'b1;
            pc_out     = ret_pc;
            pc_we      = 1'b1;
            sp_out     = sp_work;
            sp_we      = 1'b1;
            ie_next    = 1'b1;
            state_next = ACK;
         end
         ACK: begin
            busy       = 1'b1;
            clr_int    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Priority: di over ei, and entry's clear over both
      if (ei)
         ie_next = 1'b1;
      if (di)
         ie_next = 1'b0;
      if (accept)
         ie_next = 1'b0;
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: entry/exit sequencing, wait states, masking,
// SP wrap-around, reset abort and stray RETI, against a small byte memory.
module tb_int_sequencer;

   localparam logic [15:0] SP_RESET = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset, cauch_int, instr_boundary, reti, ei, di, mem_ready;
   logic [15:0] int_address, pc_in, sp_in;
   logic [15:0] pc_out, sp_out, mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        pc_we, sp_we, mem_we, mem_re, clr_int, busy, ie, in_isr;
   logic [7:0]  mem [0:65535];
   int          vectors = 0;
   int          miscompares = 0;

   int_sequencer #(.SP_RESET(SP_RESET)) dut (
      .clk(clk), .reset(reset), .cauch_int(cauch_int), .int_address(int_address),
      .instr_boundary(instr_boundary), .reti(reti), .ei(ei), .di(di),
      .pc_in(pc_in), .sp_in(sp_in), .pc_out(pc_out), .pc_we(pc_we),
      .sp_out(sp_out), .sp_we(sp_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready),
      .clr_int(clr_int), .busy(busy), .ie(ie), .in_isr(in_isr)
   );

   always #5 clk = ~clk;

   // Byte-wide data memory standing in for the bus arbiter
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk)
      if (mem_we && mem_ready)
         mem[mem_addr] <= mem_wdata;

   // Starts in IN_ISR at a falling edge; returns at the falling edge after ACK
   task automatic run_exit(input logic [15:0] sp);
      sp_in = sp; reti = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      reti = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Starts in IDLE with ie set; returns at the falling edge where IN_ISR is active
   task automatic run_entry(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] v);
      pc_in = pc; sp_in = sp; int_address = v;
      cauch_int = 1'b1; instr_boundary = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      cauch_int = 1'b0; instr_boundary = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({pc_we, sp_we, mem_we, mem_re, clr_int, busy, ie, in_isr} !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got %b want 00000000", {pc_we, sp_we, mem_we, mem_re, clr_int, busy, ie, in_isr});
      end
      vectors++;
      if ({pc_out, sp_out, mem_addr, mem_wdata} !== 56'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_buses got %h want 0", {pc_out, sp_out, mem_addr, mem_wdata});
      end
      reset = 1'b0;
   endtask

   task automatic test_entry;
      @(negedge clk); ei = 1'b1;
      @(negedge clk); ei = 1'b0;
      vectors++;
      if (ie !== 1'b1) begin
         miscompares++; $display("[TB] FAIL ei_set got %b want 1", ie);
      end
      pc_in = 16'h1234; sp_in = 16'h00FF; int_address = 16'h0080;
      cauch_int = 1'b1; instr_boundary = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      cauch_int = 1'b0; instr_boundary = 1'b0;
      pc_in = 16'hDEAD; sp_in = 16'hDEAD; int_address = 16'hDEAD;
      vectors++;
      if ({mem_we, mem_re, busy, ie} !== 4'b1010) begin
         miscompares++; $display("[TB] FAIL entry_push_hi_ctl got %b want 1010", {mem_we, mem_re, busy, ie});
      end
      vectors++;
      if ({mem_addr, mem_wdata} !== {16'h00FF, 8'h12}) begin
         miscompares++; $display("[TB] FAIL entry_push_hi got %h want 00ff12", {mem_addr, mem_wdata});
      end
      @(negedge clk);
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h00FE, 8'h34}) begin
         miscompares++; $display("[TB] FAIL entry_push_lo got %h want 100fe34", {mem_we, mem_addr, mem_wdata});
      end
      @(negedge clk);
      vectors++;
      if ({pc_we, sp_we, mem_we, pc_out, sp_out} !== {3'b110, 16'h0080, 16'h00FD}) begin
         miscompares++; $display("[TB] FAIL entry_vector got %h want 6008000fd", {pc_we, sp_we, mem_we, pc_out, sp_out});
      end
      @(negedge clk);
      vectors++;
      if ({in_isr, busy, pc_we, ie} !== 4'b1000) begin
         miscompares++; $display("[TB] FAIL entry_in_isr got %b want 1000", {in_isr, busy, pc_we, ie});
      end
   endtask

   task automatic test_reti;
      sp_in = 16'h00FD; reti = 1'b1;
      @(negedge clk);
      reti = 1'b0;
      vectors++;
      if ({mem_re, mem_we, mem_addr} !== {2'b10, 16'h00FE}) begin
         miscompares++; $display("[TB] FAIL reti_pop_lo got %h want 200fe", {mem_re, mem_we, mem_addr});
      end
      @(negedge clk);
      vectors++;
      if ({mem_re, mem_addr} !== {1'b1, 16'h00FF}) begin
         miscompares++; $display("[TB] FAIL reti_pop_hi got %h want 100ff", {mem_re, mem_addr});
      end
      @(negedge clk);
      vectors++;
      if ({pc_we, sp_we, clr_int} !== 3'b110) begin
         miscompares++; $display("[TB] FAIL reti_restore_ctl got %b want 110", {pc_we, sp_we, clr_int});
      end
      vectors++;
      if ({pc_out, sp_out} !== {16'h1234, 16'h00FF}) begin
         miscompares++; $display("[TB] FAIL reti_restore got %h want 123400ff", {pc_out, sp_out});
      end
      @(negedge clk);
      vectors++;
      if ({clr_int, busy, ie, pc_we} !== 4'b1110) begin
         miscompares++; $display("[TB] FAIL reti_ack got %b want 1110", {clr_int, busy, ie, pc_we});
      end
      @(negedge clk);
      vectors++;
      if ({clr_int, busy, in_isr} !== 3'b000) begin
         miscompares++; $display("[TB] FAIL reti_idle got %b want 000", {clr_int, busy, in_isr});
      end
   endtask

   task automatic test_wait_states;
      logic [39:0] want;
      logic [39:0] got;
      pc_in = 16'hABCD; sp_in = 16'h0200; int_address = 16'h0100;
      cauch_int = 1'b1; instr_boundary = 1'b1; mem_ready = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         cauch_int = 1'b0; instr_boundary = 1'b0;
         if (c <= 4) begin
            got  = {5'b0, mem_we, busy, pc_we, mem_addr, mem_wdata};
            want = {5'b0, 3'b110, 16'h0200, 8'hAB};
         end else if (c <= 8) begin
            got  = {5'b0, mem_we, busy, pc_we, mem_addr, mem_wdata};
            want = {5'b0, 3'b110, 16'h01FF, 8'hCD};
         end else begin
            got  = {5'b0, pc_we, sp_we, mem_we, pc_out, sp_out};
            want = {5'b0, 3'b110, 16'h0100, 16'h01FE};
         end
         vectors++;
         if (got !== want) begin
            miscompares++; $display("[TB] FAIL wait_cycle%0d got %h want %h", c, got, want);
         end
         mem_ready = (c == 4 || c == 8);
      end
      @(negedge clk);
      vectors++;
      if ({in_isr, busy} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL wait_in_isr got %b want 10", {in_isr, busy});
      end
      run_exit(16'h01FE);
   endtask

   task automatic test_masking;
      ei = 1'b1; di = 1'b1;
      @(negedge clk);
      ei = 1'b0; di = 1'b0;
      vectors++;
      if (ie !== 1'b0) begin
         miscompares++; $display("[TB] FAIL di_wins got %b want 0", ie);
      end
      pc_in = 16'h7777; sp_in = 16'h0500; int_address = 16'h0040;
      cauch_int = 1'b1; instr_boundary = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, mem_we, mem_re, in_isr} !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL mask_ie_cycle%0d got %b want 0000", c, {busy, mem_we, mem_re, in_isr});
         end
      end
      instr_boundary = 1'b0; ei = 1'b1;
      @(negedge clk);
      ei = 1'b0;
      vectors++;
      if (ie !== 1'b1) begin
         miscompares++; $display("[TB] FAIL mask_ei got %b want 1", ie);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, mem_we, mem_re, in_isr} !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL mask_boundary_cycle%0d got %b want 0000", c, {busy, mem_we, mem_re, in_isr});
         end
      end
      run_entry(16'h4000, 16'h0300, 16'h0200);
      ei = 1'b1; cauch_int = 1'b1; instr_boundary = 1'b1;
      @(negedge clk);
      ei = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({in_isr, busy, mem_we, mem_re, ie} !== 5'b10001) begin
            miscompares++; $display("[TB] FAIL no_nest_cycle%0d got %b want 10001", c, {in_isr, busy, mem_we, mem_re, ie});
         end
      end
      cauch_int = 1'b0; instr_boundary = 1'b0;
      run_exit(16'h02FE);
   endtask

   task automatic test_wrap;
      pc_in = 16'hBEEF; sp_in = 16'h0000; int_address = 16'h0010;
      cauch_int = 1'b1; instr_boundary = 1'b1; ei = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      cauch_int = 1'b0; instr_boundary = 1'b0; ei = 1'b0;
      vectors++;
      if (ie !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ei_vs_accept got %b want 0", ie);
      end
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 8'hBE}) begin
         miscompares++; $display("[TB] FAIL wrap_push_hi got %h want 10000be", {mem_we, mem_addr, mem_wdata});
      end
      @(negedge clk);
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'hFFFF, 8'hEF}) begin
         miscompares++; $display("[TB] FAIL wrap_push_lo got %h want 1ffffef", {mem_we, mem_addr, mem_wdata});
      end
      @(negedge clk);
      vectors++;
      if ({pc_we, sp_we, pc_out, sp_out} !== {2'b11, 16'h0010, 16'hFFFE}) begin
         miscompares++; $display("[TB] FAIL wrap_vector got %h want 30010fffe", {pc_we, sp_we, pc_out, sp_out});
      end
      @(negedge clk);
      sp_in = 16'hFFFE; reti = 1'b1;
      @(negedge clk);
      reti = 1'b0;
      vectors++;
      if ({mem_re, mem_we, mem_addr} !== {2'b10, 16'hFFFF}) begin
         miscompares++; $display("[TB] FAIL wrap_pop_lo got %h want 2ffff", {mem_re, mem_we, mem_addr});
      end
      @(negedge clk);
      vectors++;
      if ({mem_re, mem_addr} !== {1'b1, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL wrap_pop_hi got %h want 10000", {mem_re, mem_addr});
      end
      @(negedge clk);
      vectors++;
      if ({pc_we, sp_we, pc_out, sp_out} !== {2'b11, 16'hBEEF, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL wrap_restore got %h want 3beef0000", {pc_we, sp_we, pc_out, sp_out});
      end
      @(negedge clk);
      vectors++;
      if (clr_int !== 1'b1) begin
         miscompares++; $display("[TB] FAIL wrap_ack got %b want 1", clr_int);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      run_entry(16'h5555, 16'h0400, 16'h0020);
      sp_in = 16'h03FE; reti = 1'b1;
      @(negedge clk);
      reti = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_re, mem_addr} !== {1'b1, 16'h0400}) begin
         miscompares++; $display("[TB] FAIL abort_pop_hi got %h want 10400", {mem_re, mem_addr});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({pc_we, sp_we, mem_we, mem_re, clr_int, busy, ie, in_isr} !== 8'h00) begin
         miscompares++; $display("[TB] FAIL abort_flags got %b want 00000000", {pc_we, sp_we, mem_we, mem_re, clr_int, busy, ie, in_isr});
      end
      vectors++;
      if ({pc_out, sp_out, mem_addr, mem_wdata} !== 56'h0) begin
         miscompares++; $display("[TB] FAIL abort_buses got %h want 0", {pc_out, sp_out, mem_addr, mem_wdata});
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({clr_int, busy, pc_we, in_isr} !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL abort_quiet_cycle%0d got %b want 0000", c, {clr_int, busy, pc_we, in_isr});
         end
      end
   endtask

   task automatic test_stray_reti;
      sp_in = 16'h1000; reti = 1'b1;
      @(negedge clk);
      reti = 1'b0;
      for (int c = 0; c < 4; c++) begin
         vectors++;
         if ({mem_re, mem_we, pc_we, sp_we, clr_int, busy} !== 6'b000000) begin
            miscompares++; $display("[TB] FAIL stray_reti_cycle%0d got %b want 000000", c, {mem_re, mem_we, pc_we, sp_we, clr_int, busy});
         end
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; cauch_int = 1'b0; instr_boundary = 1'b0; reti = 1'b0;
      ei = 1'b0; di = 1'b0; mem_ready = 1'b1;
      int_address = 16'h0000; pc_in = 16'h0000; sp_in = 16'h0000;
      test_reset;
      test_entry;
      test_reti;
      test_wait_states;
      test_masking;
      test_wrap;
      test_reset_abort;
      test_stray_reti;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
